// File: rtl/voltage_display_pkg.sv
// Shared constants, FSM state type and 7-segment font for the voltage BCD display.
// Font patterns are active-low {dp,g,f,e,d,c,b,a}, with the decimal point off.
package voltage_display_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int DP_DIGIT    = 2;
  localparam int NUM_DIGITS  = 4;
  localparam int MAX_DISPLAY = 9999;
  localparam int BIN_W       = 14;
  localparam int BCD_W       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  function automatic logic [7:0] seg_font(input logic [3:0] digit);
    logic [7:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/voltage_bcd_display_bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary to 4-digit packed BCD.
// One add-3/shift iteration per clock; start/busy/done handshake.
module bin2bcd_seq
  import voltage_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

  conv_state_t      state_q, state_d;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_shift;
  logic [3:0]       iter_q;
  logic [3:0]       nib;
  logic             carry;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (iter_q == LAST_ITER) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Adjust each nibble, then shift the whole {bcd,bin} pair left by one;
  // each adjusted nibble's MSB carries into the next nibble's LSB.
  always_comb begin
    carry     = bin_q[BIN_W-1];
    nib       = '0;
    bcd_shift = '0;
    for (int i = 0; i < 4; i++) begin
      nib = bcd_q[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      bcd_shift[4*i +: 4] = {nib[2:0], carry};
      carry = nib[3];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q  <= bin;
            bcd_q  <= '0;
            iter_q <= '0;
          end
        end
        SHIFT: begin
          bcd_q  <= bcd_shift;
          bin_q  <= {bin_q[BIN_W-2:0], 1'b0};
          iter_q <= iter_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/voltage_bcd_display.sv
// Voltage (x100) to BCD conversion driving a 4-digit multiplexed "dd.dd" display.
// Optional VOLTAGE_DISPLAY_ZERO_BLANK_EN blanks a leading zero in digit 3.
module voltage_bcd_display
  import voltage_display_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCAN_HZ  = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] voltage,
  output logic [15:0] bcd_out,
  output logic        bcd_valid,
  output logic [7:0]  seg,
  output logic [3:0]  sel
);

  localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
  localparam int CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [BIN_W-1:0] clamped;
  logic [BIN_W-1:0] last_q;
  logic             start;
  logic             busy;
  logic             done;
  logic [BCD_W-1:0] bcd_res;

  assign clamped = (voltage > 16'(MAX_DISPLAY)) ? BIN_W'(MAX_DISPLAY) : voltage[BIN_W-1:0];
  // Only compared while idle, so a value that changed mid-conversion is picked up next.
  assign start   = !busy && (clamped != last_q);

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (clamped),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= '0;
      bcd_out <= '0;
    end else begin
      if (start) last_q <= clamped;
      if (done) bcd_out <= bcd_res;
    end
  end

  assign bcd_valid = done;

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic             tick;
  logic [3:0]       cur_nib;
  logic [7:0]       seg_d;
  logic [3:0]       sel_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cur_nib = bcd_out[{idx_q, 2'b00} +: 4];
    seg_d   = seg_font(cur_nib);
    if (idx_q == 2'(DP_DIGIT)) seg_d[7] = 1'b0;
`ifdef VOLTAGE_DISPLAY_ZERO_BLANK_EN
    if ((idx_q == 2'(NUM_DIGITS - 1)) && (cur_nib == 4'd0)) seg_d = SEG_BLANK;
`endif
    sel_d = ~(4'b0001 << idx_q);
  end

  // seg and sel update on the same edge so a digit never shows its neighbour's pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg   <= SEG_BLANK;
      sel   <= 4'hF;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        seg   <= seg_d;
        sel   <= sel_d;
        idx_q <= idx_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_voltage_bcd_display.sv
// Directed self-checking bench for voltage_bcd_display (SCAN_DIV = 10).
module tb_voltage_bcd_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] voltage;
  logic [15:0] bcd_out;
  logic        bcd_valid;
  logic [7:0]  seg;
  logic [3:0]  sel;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pulses = 0;
  logic [15:0] vals[$];
  bit pend = 1'b0;

  voltage_bcd_display #(.CLK_FREQ(1000), .SCAN_HZ(100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .voltage   (voltage),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .seg       (seg),
    .sel       (sel)
  );

  always #5 clk = ~clk;

  // Count pulses and capture bcd_out on the cycle after each pulse.
  always @(negedge clk) begin
    if (pend && rst_n) vals.push_back(bcd_out);
    pend = bcd_valid && rst_n;
    if (bcd_valid) n_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_pulses(input string tag, input int target, input int max_cycles);
    int c = 0;
    while (n_pulses < target && c < max_cycles) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(n_pulses >= target), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic convert(input string tag, input logic [15:0] v, input logic [15:0] exp);
    int p0 = n_pulses;
    int q0 = vals.size();
    @(negedge clk);
    voltage = v;
    wait_pulses({tag, "_pulse"}, p0 + 1, 40);
    repeat (20) @(negedge clk);
    check({tag, "_count"}, 32'(n_pulses - p0), 32'd1);
    check({tag, "_val"}, 32'(bcd_out), 32'(exp));
    if (vals.size() > q0) check({tag, "_cap"}, 32'(vals[q0]), 32'(exp));
    else check({tag, "_cap"}, 32'hDEAD, 32'(exp));
  endtask

  task automatic expect_no_conv(input string tag, input logic [15:0] v);
    int p0 = n_pulses;
    @(negedge clk);
    voltage = v;
    repeat (25) @(negedge clk);
    check(tag, 32'(n_pulses - p0), 32'd0);
  endtask

  logic [7:0] exp_seg[4];
  logic [3:0] exp_sel[4];

  initial begin
    int c;
    int p0;
    int q0;
    exp_sel[0] = 4'hE; exp_sel[1] = 4'hD; exp_sel[2] = 4'hB; exp_sel[3] = 4'h7;
    exp_seg[0] = 8'h82; exp_seg[1] = 8'hF8; exp_seg[2] = 8'h30;
`ifdef VOLTAGE_DISPLAY_ZERO_BLANK_EN
    exp_seg[3] = 8'hFF;
`else
    exp_seg[3] = 8'hC0;
`endif

    rst_n   = 1'b0;
    voltage = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_valid", 32'(bcd_valid), 32'h0);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_sel", 32'(sel), 32'hF);
    rst_n = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("tick_early_sel", 32'(sel), 32'hF);
    @(negedge clk);
    check("tick_first_sel", 32'(sel), 32'hE);
    check("tick_first_seg", 32'(seg), 32'hC0);
    repeat (20) @(negedge clk);
    check("zero_no_pulse", 32'(n_pulses), 32'd0);

    // Exact latency for 376
    @(negedge clk);
    voltage = 16'd376;
    @(posedge clk);
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("lat_pre_valid", 32'(bcd_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(bcd_valid), 32'd1);
    @(negedge clk);
    check("lat_bcd", 32'(bcd_out), 32'h0376);
    check("lat_valid_one", 32'(bcd_valid), 32'd0);

    // Scan: align on digit 0, then walk all four with dwell check
    repeat (40) @(negedge clk);
    c = 0;
    while (sel == 4'hE && c < 60) begin @(negedge clk); c++; end
    while (sel != 4'hE && c < 60) begin @(negedge clk); c++; end
    check("scan_align", 32'(c < 60), 32'd1);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("scan_sel%0d", d), 32'(sel), 32'(exp_sel[d]));
      check($sformatf("scan_seg%0d", d), 32'(seg), 32'(exp_seg[d]));
      repeat (9) @(negedge clk);
      check($sformatf("scan_dwell%0d", d), 32'(sel), 32'(exp_sel[d]));
      @(negedge clk);
    end
    check("scan_wrap", 32'(sel), 32'hE);
    check("steady_pulses", 32'(n_pulses), 32'd1);

    convert("clamp12000", 16'd12000, 16'h9999);
    expect_no_conv("clamp_same9999", 16'd9999);
    expect_no_conv("clamp_same10000", 16'd10000);
    convert("v665", 16'd665, 16'h0665);
    convert("v0", 16'd0, 16'h0000);
    convert("v9998", 16'd9998, 16'h9998);

    // Change mid-conversion: both values must come out, in order
    p0 = n_pulses;
    q0 = vals.size();
    @(negedge clk);
    voltage = 16'd376;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    voltage = 16'd500;
    wait_pulses("mid_pulses", p0 + 2, 60);
    repeat (30) @(negedge clk);
    check("mid_count", 32'(n_pulses - p0), 32'd2);
    if (vals.size() >= q0 + 2) begin
      check("mid_first", 32'(vals[q0]), 32'h0376);
      check("mid_second", 32'(vals[q0 + 1]), 32'h0500);
    end else begin
      check("mid_captures", 32'(vals.size() - q0), 32'd2);
    end
    check("mid_final", 32'(bcd_out), 32'h0500);

    // Reset during SHIFT aborts; value is reconverted after release
    @(negedge clk);
    voltage = 16'd250;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_bcd", 32'(bcd_out), 32'h0);
    check("arst_valid", 32'(bcd_valid), 32'd0);
    check("arst_seg", 32'(seg), 32'hFF);
    check("arst_sel", 32'(sel), 32'hF);
    p0 = n_pulses;
    q0 = vals.size();
    repeat (20) @(negedge clk);
    check("arst_no_pulse", 32'(n_pulses - p0), 32'd0);
    rst_n = 1'b1;
    wait_pulses("arst_reconv", p0 + 1, 40);
    repeat (20) @(negedge clk);
    check("arst_count", 32'(n_pulses - p0), 32'd1);
    check("arst_val", 32'(bcd_out), 32'h0250);
    if (vals.size() > q0) check("arst_cap", 32'(vals[q0]), 32'h0250);
    else check("arst_cap", 32'hDEAD, 32'h0250);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
